// File: rtl/z80_irq_stim.sv
// z80_irq_stim: per-channel off/one-shot/periodic/level stimulus generator for Z80 control pins.
// IRQSTIM_JITTER_EN adds LFSR gap jitter; cfg_ch is one bit wider than needed so channel NUM_CH can be addressed and ignored.
module z80_irq_stim #(
   parameter int NUM_CH = 4,
   parameter int CNT_W = 16,
   parameter logic [NUM_CH-1:0] ACT_LOW = 4'hF,
   localparam int CH_W = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              fpga_reset,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_sel,
   input  logic [CNT_W-1:0]  cfg_data,
   input  logic [NUM_CH-1:0] ack,
   output logic [NUM_CH-1:0] stim_out,
   output logic [NUM_CH-1:0] busy
);
   typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, HOLD} st_t;
   localparam logic [1:0] OFF = 2'd0, PERIODIC = 2'd2, LEVEL = 2'd3;
   localparam logic [CNT_W:0] MAXC = {1'b0, {CNT_W{1'b1}}};
   st_t st [NUM_CH];
   logic [1:0] mode [NUM_CH];
   logic [CNT_W-1:0] dly [NUM_CH], per [NUM_CH], wid [NUM_CH], cnt [NUM_CH], gap [NUM_CH];
   logic [CNT_W-1:0] wn [NUM_CH], gn [NUM_CH];
   logic [CNT_W:0] ex [NUM_CH], pe [NUM_CH];
   logic [NUM_CH-1:0] act, ack_seen, hit;
   logic [2:0] jit;
`ifdef IRQSTIM_JITTER_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk)
      lfsr <= fpga_reset ? 16'hACE1 : {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign jit = lfsr[2:0];
`else
   assign jit = 3'd0;
`endif
   assign stim_out = act ^ ACT_LOW;
   // gn is the deasserted count between pulses so the next assertion lands exactly one effective period later
   always_comb
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = cfg_we && cfg_ch == CH_W'(i);
         wn[i] = (wid[i] == '0) ? CNT_W'(1) : wid[i];
         ex[i] = ({1'b0, per[i]} > {1'b0, wn[i]}) ? {1'b0, per[i]} : {1'b0, wn[i]} + 1'b1;
         pe[i] = (ex[i] + (CNT_W+1)'(jit) > MAXC) ? MAXC : ex[i] + (CNT_W+1)'(jit);
         gn[i] = (pe[i] > {1'b0, wn[i]}) ? CNT_W'(pe[i] - {1'b0, wn[i]} - 1'b1) : '0;
      end
   always_ff @(posedge clk)
      if (fpga_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st[i] <= IDLE;
            mode[i] <= OFF;
            dly[i] <= '0;
            per[i] <= '0;
            wid[i] <= '0;
            cnt[i] <= '0;
            gap[i] <= '0;
         end
         act <= '0;
         ack_seen <= '0;
         busy <= '0;
      end else
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i] && cfg_sel == 2'd1) dly[i] <= cfg_data;
            if (hit[i] && cfg_sel == 2'd2) per[i] <= cfg_data;
            if (hit[i] && cfg_sel == 2'd3) wid[i] <= cfg_data;
            if (hit[i] && cfg_sel == 2'd0) begin
               mode[i] <= cfg_data[1:0];
               st[i] <= (cfg_data[1:0] == OFF) ? IDLE : DELAY;
               busy[i] <= cfg_data[1:0] != OFF;
               cnt[i] <= dly[i];
               act[i] <= 1'b0;
               ack_seen[i] <= 1'b0;
            end else
               case (st[i])
                  DELAY, GAP:
                     if (cnt[i] == '0) begin
                        act[i] <= 1'b1;
                        st[i] <= (mode[i] == LEVEL) ? HOLD : PULSE;
                        cnt[i] <= wn[i] - 1'b1;
                        gap[i] <= gn[i];
                     end else
                        cnt[i] <= cnt[i] - 1'b1;
                  PULSE:
                     if (cnt[i] == '0) begin
                        act[i] <= 1'b0;
                        st[i] <= (mode[i] == PERIODIC) ? GAP : IDLE;
                        busy[i] <= mode[i] == PERIODIC;
                        cnt[i] <= gap[i];
                     end else
                        cnt[i] <= cnt[i] - 1'b1;
                  HOLD: begin
                     ack_seen[i] <= ack[i] & ~ack_seen[i];
                     if (ack_seen[i]) begin
                        act[i] <= 1'b0;
                        busy[i] <= 1'b0;
                        st[i] <= IDLE;
                     end
                  end
                  default: ;
               endcase
         end
endmodule

// File: tb/tb_z80_irq_stim.sv
// tb_z80_irq_stim: directed checks of reset, one-shot, periodic, level/ack, abort, range and reset-abort behaviour.
module tb_z80_irq_stim;
   logic clk = 0, fpga_reset = 0, cfg_we = 0;
   logic [2:0] cfg_ch = '0;
   logic [1:0] cfg_sel = '0;
   logic [15:0] cfg_data = '0;
   logic [3:0] ack = '0;
   logic [3:0] stim_out, busy;
   int total = 0, bad = 0;
   int prev, exp_sp;
   logic was;
   always #5 clk = ~clk;
   z80_irq_stim dut (
      .clk(clk), .fpga_reset(fpga_reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .ack(ack), .stim_out(stim_out), .busy(busy)
   );
`ifdef IRQSTIM_JITTER_EN
   logic [15:0] tl, tl_used;
   always @(posedge clk) begin
      tl_used <= tl;
      tl <= fpga_reset ? 16'hACE1 : {tl[0] ^ tl[2] ^ tl[3] ^ tl[5], tl[15:1]};
   end
`endif
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wr(int ch, int sel, int data);
      cfg_we = 1;
      cfg_ch = 3'(ch);
      cfg_sel = 2'(sel);
      cfg_data = 16'(data);
      tick();
      cfg_we = 0;
   endtask
   initial begin
      fpga_reset = 1;
      tick();
      fpga_reset = 0;
      chk("reset_out", stim_out, 4'hF);
      chk("reset_busy", busy, 4'h0);
      // one-shot: delay 5, width 3 -> low on k+6..k+8
      wr(1, 1, 5);
      wr(1, 3, 3);
      wr(1, 0, 1);
      chk("os_busy_k", busy[1], 1);
      chk("os_out_k", stim_out[1], 1);
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk($sformatf("os_out_k%0d", e), stim_out[1], (e >= 6 && e <= 8) ? 0 : 1);
         chk($sformatf("os_busy_k%0d", e), busy[1], (e < 9) ? 1 : 0);
      end
`ifndef IRQSTIM_JITTER_EN
      // periodic: width 2, period 10 -> low at k+1,k+2,k+11,k+12,k+21,k+22
      wr(0, 1, 0);
      wr(0, 3, 2);
      wr(0, 2, 10);
      wr(0, 0, 2);
      for (int e = 1; e <= 25; e++) begin
         tick();
         chk($sformatf("per10_k%0d", e), stim_out[0], ((e - 1) % 10 < 2) ? 0 : 1);
      end
      wr(0, 0, 0);
      chk("per_off_busy", busy[0], 0);
      // period 2 <= width 2 -> effective period 3
      wr(0, 2, 2);
      wr(0, 0, 2);
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk($sformatf("per2_k%0d", e), stim_out[0], ((e - 1) % 3 < 2) ? 0 : 1);
      end
      wr(0, 0, 0);
`endif
      // abort during PULSE
      wr(0, 1, 0);
      wr(0, 3, 4);
      wr(0, 2, 10);
      wr(0, 0, 2);
      tick();
      tick();
      chk("abort_pre", stim_out[0], 0);
      wr(0, 0, 0);
      chk("abort_out", stim_out[0], 1);
      chk("abort_busy", busy[0], 0);
      tick();
      chk("abort_after", stim_out[0], 1);
      // level: delay 4 -> low from k+5, early ack ignored, ack at k+20 -> high at k+21
      wr(0, 1, 4);
      wr(0, 0, 3);
      for (int e = 1; e <= 19; e++) begin
         if (e == 3) ack[0] = 1;
         tick();
         ack[0] = 0;
         chk($sformatf("lvl_k%0d", e), stim_out[0], (e >= 5) ? 0 : 1);
         chk($sformatf("lvl_busy_k%0d", e), busy[0], 1);
      end
      ack[0] = 1;
      tick();
      ack[0] = 0;
      chk("lvl_k20", stim_out[0], 0);
      tick();
      chk("lvl_k21", stim_out[0], 1);
      chk("lvl_busy_k21", busy[0], 0);
      // cfg write and ack on the same edge: the write restarts the channel
      wr(0, 1, 0);
      wr(0, 0, 3);
      tick();
      chk("race_pre", stim_out[0], 0);
      ack[0] = 1;
      wr(0, 0, 3);
      ack[0] = 0;
      chk("race_n", stim_out[0], 1);
      chk("race_busy", busy[0], 1);
      tick();
      chk("race_n1", stim_out[0], 0);
      tick();
      chk("race_n2", stim_out[0], 0);
      wr(0, 0, 0);
      // out-of-range channel
      wr(4, 1, 0);
      wr(4, 0, 2);
      chk("oor_busy", busy, 4'h0);
      tick();
      chk("oor_out", stim_out, 4'hF);
      // reset mid-pulse
      wr(2, 1, 0);
      wr(2, 3, 3);
      wr(2, 2, 8);
      wr(2, 0, 2);
      tick();
      chk("rst_pre", stim_out[2], 0);
      fpga_reset = 1;
      tick();
      fpga_reset = 0;
      chk("rst_out", stim_out, 4'hF);
      chk("rst_busy", busy, 4'h0);
      tick();
      tick();
      chk("rst_after", stim_out, 4'hF);
      // assertion spacing: 10, plus LFSR jitter when enabled
      wr(0, 3, 2);
      wr(0, 2, 10);
      wr(0, 0, 2);
      prev = -1;
      exp_sp = 0;
      was = 1;
      for (int e = 1; e <= 70; e++) begin
         tick();
         if (!stim_out[0] && was) begin
            if (prev >= 0) chk($sformatf("spacing_k%0d", e), e - prev, exp_sp);
            prev = e;
`ifdef IRQSTIM_JITTER_EN
            exp_sp = 10 + int'(tl_used[2:0]);
`else
            exp_sp = 10;
`endif
         end
         was = stim_out[0];
      end
      chk("spacing_seen", prev > 40, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
